// File: rtl/special_alu_sched_if.sv
// Handshake bundle between the requesters, the scheduler and the ALU result side.
// Ports: req_*/rsp_* per-requester command/response lanes, alu_* ALU result side.
interface special_alu_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [10:0]       rsp_data;
    logic              rsp_err;
    logic [2:0]        alu_op;
    logic              alu_b_ready;
    logic              alu_b_valid;
    logic [10:0]       alu_b_result;

    modport slave (
        input  req_valid, req_op, rsp_ready, alu_b_valid, alu_b_result,
        output req_ready, rsp_valid, rsp_data, rsp_err, alu_op, alu_b_ready
    );

    modport master (
        output req_valid, req_op, rsp_ready, alu_b_valid, alu_b_result,
        input  req_ready, rsp_valid, rsp_data, rsp_err, alu_op, alu_b_ready
    );
endinterface

// File: rtl/special_alu_sched.sv
// Round-robin scheduler sharing the special_alu result side among NREQ requesters.
// Ports: clk, rstn (async low), bus (slave modport), busy, err_cnt (saturating timeouts).
module special_alu_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rstn,
    special_alu_sched_if.slave  bus,
    output logic                busy,
    output logic [7:0]          err_cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   grant_q;
    logic [IW-1:0]   last_q;
    logic [2:0]      op_q;
    logic [TW-1:0]   timer_q;
    logic [10:0]     data_q;
    logic            err_q;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW-1:0]   cand;
    logic            tmo;

    // Search upward from the requester after the last one served.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign tmo = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d         = state;
        bus.req_ready   = '0;
        bus.rsp_valid   = '0;
        bus.alu_b_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    bus.req_ready[win] = 1'b1;
                    state_d            = WAIT;
                end
            end
            WAIT: begin
                // A result present on the limit cycle beats the timeout.
                bus.alu_b_ready = bus.alu_b_valid;
                if (bus.alu_b_valid || tmo) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid[grant_q] = 1'b1;
                if (bus.rsp_ready[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.alu_op   = op_q;
    assign bus.rsp_data = data_q;
    assign bus.rsp_err  = err_q;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NREQ - 1);
            op_q    <= '0;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            state <= state_d;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= win;
                        op_q    <= bus.req_op[3*int'(win) +: 3];
                        timer_q <= '0;
                    end
                end
                WAIT: begin
                    if (bus.alu_b_valid) begin
                        data_q <= bus.alu_b_result;
                        err_q  <= 1'b0;
                    end else if (tmo) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[grant_q]) begin
                        last_q <= grant_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_special_alu_sched.sv
// Self-checking bench for special_alu_sched: directed steps then a random run
// checked against a transaction-level model with an ALU result queue.
module tb_special_alu_sched;
    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic       clk;
    logic       rstn;
    logic       busy;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    special_alu_sched_if #(.NREQ(NREQ)) bus ();

    special_alu_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus.slave),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int last, input logic [3:0] v);
        for (int i = 1; i <= NREQ; i++) begin
            if (v[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // Reference model state for the random run.
    int          m_phase;   // 0 no command, 1 awaiting result, 2 response held
    int          m_last;
    int          m_grant;
    int          m_wait;
    logic [2:0]  m_op;
    logic [10:0] m_data;
    logic        m_err;
    int          m_cnt;
    logic [10:0] fifo[$];

    initial begin
        int ops[4] = '{6, 1, 5, 3};
        int w;
        int g;
        int ph;
        logic [11:0] opv;

        rstn             = 1'b0;
        bus.req_valid    = '0;
        bus.req_op       = '0;
        bus.rsp_ready    = '0;
        bus.alu_b_valid  = 1'b0;
        bus.alu_b_result = '0;
        #3;
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 0);
        chk("rst_alu_op", 32'(bus.alu_op), 0);
        chk("rst_b_ready", 32'(bus.alu_b_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);

        // Single request with the ALU ready on the first WAIT cycle.
        tick();
        rstn          = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        chk("single_accept", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid    = '0;
        bus.alu_b_valid  = 1'b1;
        bus.alu_b_result = 11'h00F;
        #1;
        chk("single_pop", 32'(bus.alu_b_ready), 1);
        chk("single_busy", 32'(busy), 1);
        tick();
        // Backpressure: other requesters and ALU valid must be ignored.
        bus.alu_b_result = 11'h123;
        bus.req_valid    = 4'b1110;
        bus.rsp_ready    = 4'b1110;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
            chk("bp_rsp_data", 32'(bus.rsp_data), 32'h00F);
            chk("bp_rsp_err", 32'(bus.rsp_err), 0);
            chk("bp_b_ready", 32'(bus.alu_b_ready), 0);
            chk("bp_req_ready", 32'(bus.req_ready), 0);
            tick();
        end
        bus.rsp_ready = 4'b0001;
        tick();
        bus.rsp_ready = '0;
        #1;
        chk("rr_after_0", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid   = '0;
        bus.alu_b_valid = 1'b0;
        #1;
        chk("mid_wait_busy", 32'(busy), 1);

        // Asynchronous reset in the middle of WAIT.
        rstn            = 1'b0;
        bus.alu_b_valid = 1'b1;
        #1;
        chk("mrst_req_ready", 32'(bus.req_ready), 0);
        chk("mrst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mrst_rsp_data", 32'(bus.rsp_data), 0);
        chk("mrst_rsp_err", 32'(bus.rsp_err), 0);
        chk("mrst_b_ready", 32'(bus.alu_b_ready), 0);
        chk("mrst_alu_op", 32'(bus.alu_op), 0);
        chk("mrst_busy", 32'(busy), 0);
        bus.req_valid = 4'b1111;
        #1;
        chk("mrst_prio0", 32'(bus.req_ready), 32'b0001);

        // Round-robin with all requesters active.
        tick();
        rstn          = 1'b1;
        opv           = 12'b011_101_001_110;
        bus.req_op    = opv;
        bus.rsp_ready = 4'b1111;
        for (int c = 0; c < 15; c++) begin
            g                = (c / 3) % NREQ;
            ph               = c % 3;
            bus.alu_b_result = 11'(11'h40 + g);
            #1;
            chk("rr_req_ready", 32'(bus.req_ready), (ph == 0) ? (1 << g) : 0);
            chk("rr_b_ready", 32'(bus.alu_b_ready), (ph == 1) ? 1 : 0);
            chk("rr_rsp_valid", 32'(bus.rsp_valid), (ph == 2) ? (1 << g) : 0);
            if (ph == 1) chk("rr_alu_op", 32'(bus.alu_op), 32'(ops[g]));
            if (ph == 2) chk("rr_rsp_data", 32'(bus.rsp_data), 32'(11'h40 + g));
            tick();
        end

        // Timeout with the ALU never valid.
        bus.req_valid   = 4'b0001;
        bus.alu_b_valid = 1'b0;
        bus.rsp_ready   = 4'b0001;
        #1;
        chk("tmo_accept", 32'(bus.req_ready), 32'b0001);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            bus.req_valid = '0;
            #1;
            chk("tmo_wait", 32'(bus.rsp_valid), 0);
        end
        tick();
        chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("tmo_rsp_err", 32'(bus.rsp_err), 1);
        chk("tmo_rsp_data", 32'(bus.rsp_data), 0);
        chk("tmo_err_cnt", 32'(err_cnt), 1);
        tick();

        // Result arrives exactly on the timer limit cycle.
        bus.req_valid = 4'b0001;
        #1;
        chk("bnd_accept", 32'(bus.req_ready), 32'b0001);
        for (int k = 1; k < TMO; k++) begin
            tick();
            bus.req_valid = '0;
            #1;
            chk("bnd_wait", 32'(bus.alu_b_ready), 0);
        end
        tick();
        bus.alu_b_valid  = 1'b1;
        bus.alu_b_result = 11'h2AA;
        #1;
        chk("bnd_pop", 32'(bus.alu_b_ready), 1);
        tick();
        bus.alu_b_valid = 1'b0;
        #1;
        chk("bnd_rsp_valid", 32'(bus.rsp_valid), 32'b0001);
        chk("bnd_rsp_err", 32'(bus.rsp_err), 0);
        chk("bnd_rsp_data", 32'(bus.rsp_data), 32'h2AA);
        chk("bnd_err_cnt", 32'(err_cnt), 1);
        tick();

        // 300 further timeouts saturate the error counter.
        for (int t = 0; t < 300; t++) begin
            bus.req_valid = 4'b0001;
            tick();
            bus.req_valid = '0;
            repeat (TMO) tick();
            chk("sat_rsp_err", 32'(bus.rsp_err), 1);
            chk("sat_err_cnt", 32'(err_cnt), (t + 2 > 255) ? 255 : t + 2);
            tick();
        end

        // Random traffic against the model.
        rstn          = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        tick();
        rstn    = 1'b1;
        m_phase = 0;
        m_last  = NREQ - 1;
        m_grant = 0;
        m_wait  = 0;
        m_op    = '0;
        m_data  = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
        fifo.delete();
        for (int c = 0; c < 3000; c++) begin
            logic popped;
            bus.req_valid    = 4'($urandom_range(0, 15));
            bus.req_op       = 12'($urandom);
            bus.rsp_ready    = 4'($urandom_range(0, 15));
            bus.alu_b_valid  = (fifo.size() > 0);
            bus.alu_b_result = (fifo.size() > 0) ? fifo[0] : 11'h0;
            #1;
            w = pick(m_last, bus.req_valid);
            chk("rnd_req_ready", 32'(bus.req_ready),
                (m_phase == 0 && w >= 0) ? (1 << w) : 0);
            chk("rnd_b_ready", 32'(bus.alu_b_ready),
                (m_phase == 1 && fifo.size() > 0) ? 1 : 0);
            chk("rnd_rsp_valid", 32'(bus.rsp_valid),
                (m_phase == 2) ? (1 << m_grant) : 0);
            chk("rnd_rsp_data", 32'(bus.rsp_data), 32'(m_data));
            chk("rnd_rsp_err", 32'(bus.rsp_err), 32'(m_err));
            chk("rnd_alu_op", 32'(bus.alu_op), 32'(m_op));
            chk("rnd_busy", 32'(busy), (m_phase != 0) ? 1 : 0);
            chk("rnd_err_cnt", 32'(err_cnt), 32'(m_cnt));
            popped = 1'b0;
            if (m_phase == 0) begin
                if (w >= 0) begin
                    m_grant = w;
                    m_op    = bus.req_op[3*w +: 3];
                    m_wait  = 0;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (fifo.size() > 0) begin
                    m_data  = fifo[0];
                    m_err   = 1'b0;
                    popped  = 1'b1;
                    m_phase = 2;
                end else if (m_wait == TMO - 1) begin
                    m_data  = '0;
                    m_err   = 1'b1;
                    m_cnt   = (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_phase = 2;
                end else begin
                    m_wait++;
                end
            end else begin
                if (bus.rsp_ready[m_grant]) begin
                    m_last  = m_grant;
                    m_phase = 0;
                end
            end
            if (popped) void'(fifo.pop_front());
            if ($urandom_range(0, 5) == 0) fifo.push_back(11'($urandom));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/special_alu_sched.md
# special_alu_sched

Round-robin scheduler that shares the result side of `special_alu` between NREQ requesters. Each requester issues one opcode at a time. The scheduler drives `b_operation` and waits for `b_valid`. It pops the ALU with a single-cycle `b_ready` and returns the captured 11-bit result to the winning requester through a held response handshake. A configurable timeout returns an error response when the ALU cannot produce a result, for example when the FIFO holds too few operands.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 16, WAIT-state cycle limit before an error response; 0 disables the timeout
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester command valid
- req_op  in  3*NREQ  per-requester opcode; requester k uses bits [3k+2:3k], encoded as ALU ops 0..7
- req_ready  out  NREQ  one-hot command accept; at most one bit set
- rsp_valid  out  NREQ  one-hot response valid for the granted requester
- rsp_ready  in  NREQ  per-requester response accept
- rsp_data  out  11  response result, shared by all requesters
- rsp_err  out  1  response is a timeout error
- alu_op  out  3  drives ALU `b_operation`
- alu_b_ready  out  1  drives ALU `b_ready`
- alu_b_valid  in  1  from ALU `b_valid`
- alu_b_result  in  11  from ALU `b_result`
- busy  out  1  state is not IDLE
- err_cnt  out  8  saturating count of timeout responses

## Operation
- States:
  - IDLE: no command held.
  - WAIT: command held, waiting for the ALU.
  - RESP: response held for the granted requester.
- Registers:
  - `grant_q` (index)
  - `last_q` (index of the last requester served)
  - `op_q` (3 bits)
  - `timer_q`
  - `data_q` (11 bits)
  - `err_q`
  - `err_cnt`
- Arbitration: in IDLE, the winner is the first requester with `req_valid` set, searching upward from `last_q+1` modulo NREQ.
- IDLE:
  - `req_ready[winner]=1`, combinational.
  - On accept: `grant_q<=winner`, `op_q<=req_op[winner]`, `timer_q<=0`, go to WAIT.
  - With no `req_valid` set, `req_ready` is all zero and the state stays IDLE.
- WAIT:
  - `alu_op=op_q`.
  - `alu_b_ready = alu_b_valid`, combinational, asserted in WAIT only.
  - If `alu_b_valid`: `data_q<=alu_b_result`, `err_q<=0`, go to RESP. This pops exactly one ALU entry.
  - Else if TIMEOUT≠0 and `timer_q==TIMEOUT-1`: `data_q<=0`, `err_q<=1`, `err_cnt` +1 saturating at 255, go to RESP.
  - Otherwise `timer_q` +1.
- RESP:
  - `rsp_valid[grant_q]=1`; `rsp_data=data_q`; `rsp_err=err_q`.
  - On `rsp_ready[grant_q]`: `last_q<=grant_q`, go to IDLE.
  - `rsp_ready` from other requesters is ignored.
- `alu_op` equals `op_q` in every state. `alu_b_ready` is 0 outside WAIT.
- `rsp_data` and `rsp_err` are qualified by `rsp_valid` only. Their values outside RESP are don't-care, but they hold `data_q`/`err_q`.
- Requester `req_op` may change freely while that requester is not being accepted. Only the value at accept is used.
- The scheduler never touches the ALU operand (`a_*`) side.

## Timing
- Reset values:
  - State IDLE.
  - `last_q=NREQ-1`, so requester 0 has first priority after reset.
  - `op_q=0`, `alu_op=0`.
  - `alu_b_ready=0`, `req_ready=0` when no request is pending.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`.
  - `busy=0`, `err_cnt=0`.
- Latency:
  - Accept at cycle N.
  - WAIT starts at N+1. If `alu_b_valid` is high at N+1, the pop happens at N+1 and `rsp_valid` rises at N+2 (minimum 2 cycles).
  - Timeout case: `rsp_valid` rises at N+1+TIMEOUT.
- Back-to-back: `rsp_ready` at cycle M, IDLE at M+1, next accept possible at M+1. This gives one command per 3 cycles at best.
- Single pop: exactly one `alu_b_ready` cycle per successful command.
- Simultaneous events: if `alu_b_valid` arrives in the same cycle the timer reaches its limit, the valid result wins (no error, `err_cnt` unchanged).
- Reset mid-operation: any state returns to IDLE within the reset assertion. The held command and response are discarded and no pop is issued.
- `busy` is combinational from the state.

## Test plan
- Single request, ALU ready: `req_valid[0]=1`, `req_op`=0 (ADD2), `alu_b_valid=1`, `alu_b_result`=0x00F at N+1.
  - Required: `req_ready[0]` at N, `alu_b_ready` for one cycle at N+1.
  - Required: `rsp_valid[0]` from N+2 with `rsp_data=0x00F` and `rsp_err=0`, held until `rsp_ready[0]`.
- Round-robin: all four `req_valid` held high, responses accepted immediately.
  - Required: grant order 0,1,2,3,0 with 3-cycle spacing, and one ALU pop per grant.
- Timeout: TIMEOUT=16, `alu_b_valid` held 0.
  - Required: `rsp_valid` at N+17 with `rsp_err=1`, `rsp_data=0`, and `err_cnt` 0→1.
  - Required: 300 timeouts leave `err_cnt` at 255.
- Boundary: `alu_b_valid` first rises exactly at the timer limit cycle.
  - Required: a normal response with the result, and `err_cnt` unchanged.
- Response backpressure and reset: hold `rsp_ready=0` for 10 cycles.
  - Required: `rsp_valid` and `rsp_data` stable, `alu_b_ready` stays 0, no other `req_ready`.
  - Required: deasserting `rstn` mid-WAIT returns all outputs to their reset values immediately, and requester 0 wins first afterwards.
